// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR filter chain.
// The FIR filter and the output decimator both import this package.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  typedef enum logic {
    ST_WARMUP,
    ST_ACCUM
  } state_e;

endpackage

// File: rtl/fir_out_decimator_sync_fifo.sv
// Synchronous show-ahead FIFO. Storage depth is a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; level_q gates visibility, so stale words never reach dout.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/fir_out_decimator.sv
// Post-FIR stage: drops the start-up transient, boxcar-averages blocks of 2**LOG2_DECIM samples
// with round-half-up and saturation, and queues results behind a valid/ready interface.
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int LOG2_DECIM = 2,
  parameter int WARMUP     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  sample_t                       in_sample,
  input  logic                          in_en,
  output sample_t                       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int     R     = 1 << LOG2_DECIM;
  localparam int     ACC_W = SAMPLE_W + LOG2_DECIM;
  localparam int     DCW   = (LOG2_DECIM < 1) ? 1 : LOG2_DECIM;
  localparam int     WCW   = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam state_e RST_STATE = (WARMUP == 0) ? ST_ACCUM : ST_WARMUP;
  localparam logic signed [ACC_W:0] BIAS = (ACC_W+1)'(R / 2);

  state_e                  state_q, state_d;
  logic [WCW-1:0]          warm_cnt_q, warm_cnt_d;
  logic [DCW-1:0]          dec_cnt_q, dec_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    overflow_q, overflow_d;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   biased;
  logic signed [ACC_W:0]   scaled;
  sample_t                 result;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    fifo_full;
  logic                    fifo_empty;

  // A full block of R int16 samples fits in ACC_W bits, so the sum itself never wraps.
  always_comb begin
    sum    = acc_q + ACC_W'(in_sample);
    biased = (ACC_W+1)'(sum) + BIAS;
    scaled = biased >>> LOG2_DECIM;
    if (scaled > (ACC_W+1)'(SAT_MAX)) begin
      result = SAT_MAX;
    end else if (scaled < (ACC_W+1)'(SAT_MIN)) begin
      result = SAT_MIN;
    end else begin
      result = sample_t'(scaled);
    end
  end

  // NOTE: every combinational output gets a default first, so no path through the block infers a latch.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    acc_d      = acc_q;
    push       = 1'b0;
    if (in_en) begin
      unique case (state_q)
        ST_WARMUP: begin
          if (warm_cnt_q == WCW'(WARMUP - 1)) begin
            state_d    = ST_ACCUM;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
        ST_ACCUM: begin
          if (dec_cnt_q == DCW'(R - 1)) begin
            push      = 1'b1;
            acc_d     = '0;
            dec_cnt_d = '0;
          end else begin
            acc_d     = sum;
            dec_cnt_d = dec_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = push && fifo_full && !pop;

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RST_STATE;
      warm_cnt_q <= '0;
      dec_cnt_q  <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   (result),
    .pop   (pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
